mul_seq_param: RTL



---
 rtl/mul_seq_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Takes one add-and-shift step per cycle and supports signed/unsigned operands and optional early termination.
`timescale 1ns/1ps
module mul_seq_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_SIZE    = 8,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             a_in,
  input  logic [DATA_WIDTH-1:0]             b_in,
  input  logic                              signed_mode,
  input  logic [ID_SIZE-1:0]                id_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ID_SIZE+2*DATA_WIDTH:0]     result,
  output logic                              busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned RW = ID_SIZE + 1 + PW;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     mcand, mcand_n;
  logic [W-1:0]      mplier, mplier_n;
  logic [PW-1:0]     acc, acc_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              neg, neg_n;
  logic [ID_SIZE-1:0] id_r, id_n;
  logic              sm_r, sm_n;
  logic [RW-1:0]     result_r, result_n;

  logic [W-1:0]      a_mag, b_mag;
  logic [PW-1:0]     acc_add;
  logic [W-1:0]      mplier_shr;
  logic              last_step;

  // Operand magnitudes; the most negative value maps to 2^(W-1), which still fits in W bits.
  assign a_mag      = (signed_mode && a_in[W-1]) ? (~a_in) + W'(1) : a_in;
  assign b_mag      = (signed_mode && b_in[W-1]) ? (~b_in) + W'(1) : b_in;
  assign acc_add    = acc + (mplier[0] ? mcand : '0);
  assign mplier_shr = mplier >> 1;
  assign last_step  = (cnt == CW'(W - 1)) || ((EARLY_TERM != 0) && (mplier_shr == '0));

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    neg_n    = neg;
    id_n     = id_r;
    sm_n     = sm_r;
    result_n = result_r;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          mcand_n  = PW'(a_mag);
          mplier_n = b_mag;
          acc_n    = '0;
          cnt_n    = '0;
          neg_n    = signed_mode & (a_in[W-1] ^ b_in[W-1]);
          id_n     = id_in;
          sm_n     = signed_mode;
          state_n  = S_CALC;
        end
      end
      S_CALC: begin
        acc_n    = acc_add;
        mcand_n  = mcand << 1;
        mplier_n = mplier_shr;
        cnt_n    = cnt + CW'(1);
        if (last_step) begin
          result_n = {id_r, sm_r, (neg ? (~acc_add) + PW'(1) : acc_add)};
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      id_r     <= '0;
      sm_r     <= 1'b0;
      result_r <= '0;
    end else begin
      state    <= state_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      neg      <= neg_n;
      id_r     <= id_n;
      sm_r     <= sm_n;
      result_r <= result_n;
    end
  end

  // Handshake flags are decoded directly from the state register.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = result_r;

endmodule
